accumulator_sequencer: RTL and testbench



---
 rtl/accumulator_sequencer.sv | 138 +++++++++++++
 tb/tb_accumulator_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator datapath.
// Drives memory and ALU controls; holds PC, IR, AC and MBR.
//
// state         | meaning
// --------------+-----------------------------------------------
// FETCH         | present PC to memory for the instruction read
// IR_LATCH      | capture instruction word, advance PC
// DECODE        | branch on opcode; resolve JUMP/JZ/HALT/illegal
// OPERAND       | present X to memory for the operand read
// OPERAND_LATCH | capture operand into MBR
// EXECUTE       | write LOAD data or ALU result into AC
// WRITE         | single-cycle store of AC to M[X]
// HALTED        | stopped; only reset leaves this state
module accumulator_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_operand1,
  output logic [15:0] alu_operand2,
  input  logic [15:0] alu_result,
  output logic [11:0] pc,
  output logic [15:0] ac,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_IR_LATCH, S_DECODE, S_OPERAND,
    S_OPERAND_LATCH, S_EXECUTE, S_WRITE, S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'h9;

  state_t      state, state_nxt;
  logic [15:0] ir, mbr;
  logic [3:0]  op;
  logic [11:0] x;

  assign op = ir[15:12];
  assign x  = ir[11:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:         state_nxt = S_IR_LATCH;
      S_IR_LATCH:      state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_NOP, OP_JUMP, OP_JZ:                  state_nxt = S_FETCH;
          OP_STORE:                                state_nxt = S_WRITE;
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR:  state_nxt = S_OPERAND;
          default:                                 state_nxt = S_HALTED;
        endcase
      end
      S_OPERAND:       state_nxt = S_OPERAND_LATCH;
      S_OPERAND_LATCH: state_nxt = S_EXECUTE;
      S_EXECUTE:       state_nxt = S_FETCH;
      S_WRITE:         state_nxt = S_FETCH;
      S_HALTED:        state_nxt = S_HALTED;
      default:         state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      ac      <= 16'h0000;
      mbr     <= 16'h0000;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IR_LATCH: begin
          ir <= mem_rdata;
          pc <= pc + 12'd1;
        end
        S_DECODE: begin
          if (op == OP_JUMP) pc <= x;
          if (op == OP_JZ && ac == 16'h0000) pc <= x;
          if (op > OP_HALT) illegal <= 1'b1;
        end
        S_OPERAND_LATCH: mbr <= mem_rdata;
        S_EXECUTE:       ac  <= (op == OP_LOAD) ? mbr : alu_result;
        default: ;
      endcase
    end
  end

  // mem_we is gated by reset directly so an in-flight store cannot land.
  always_comb begin
    mem_addr   = {4'b0000, pc};
    mem_we     = 1'b0;
    alu_opcode = 4'b0000;
    halted     = 1'b0;
    case (state)
      S_OPERAND: mem_addr = {4'b0000, x};
      S_WRITE: begin
        mem_addr = {4'b0000, x};
        mem_we   = ~reset;
      end
      S_EXECUTE: begin
        case (op)
          OP_SUB:  alu_opcode = 4'b0001;
          OP_AND:  alu_opcode = 4'b1000;
          OP_OR:   alu_opcode = 4'b1001;
          default: alu_opcode = 4'b0000;
        endcase
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_wdata    = ac;
  assign alu_operand1 = ac;
  assign alu_operand2 = mbr;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: memory + ALU models, an instruction-level
// reference model checked every cycle, and directed programs with literal results.
module tb_accumulator_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_operand1, alu_operand2, alu_result, ac;
  logic        mem_we, halted, illegal;
  logic [3:0]  alu_opcode;
  logic [11:0] pc;

  accumulator_sequencer #(.RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .pc(pc), .ac(ac), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_operand1 + alu_operand2;
      4'b0001: alu_result = alu_operand1 - alu_operand2;
      4'b1000: alu_result = alu_operand1 & alu_operand2;
      4'b1001: alu_result = alu_operand1 | alu_operand2;
      default: alu_result = 16'hDEAD;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference model
  logic [15:0] m_mem [0:4095];
  logic [11:0] m_pc = 12'h000;
  logic [15:0] m_ac = 16'h0000;
  bit          m_halt = 1'b0, m_ill = 1'b0, valid = 1'b0;
  int          phase = 0;
  logic [3:0]  cur_op = 4'h0;
  logic [11:0] cur_x = 12'h000;
  logic        rst_q = 1'b0;

  always @(posedge clk) rst_q <= reset;

  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h3, 4'h4, 4'h5, 4'h6: return 6;
      4'h2: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      4'h4: return 4'b0001;
      4'h5: return 4'b1000;
      4'h6: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_q) begin
      m_pc = 12'h000; m_ac = 16'h0000; m_halt = 1'b0; m_ill = 1'b0; phase = 0; valid = 1'b1;
    end else if (valid && !m_halt) begin
      phase++;
      if (phase == ilen(cur_op)) begin
        phase = 0;
        m_pc = m_pc + 12'd1;
        case (cur_op)
          4'h0: ;
          4'h1: m_ac = m_mem[cur_x];
          4'h2: m_mem[cur_x] = m_ac;
          4'h3: m_ac = m_ac + m_mem[cur_x];
          4'h4: m_ac = m_ac - m_mem[cur_x];
          4'h5: m_ac = m_ac & m_mem[cur_x];
          4'h6: m_ac = m_ac | m_mem[cur_x];
          4'h7: m_pc = cur_x;
          4'h8: if (m_ac == 16'h0000) m_pc = cur_x;
          4'h9: m_halt = 1'b1;
          default: begin m_halt = 1'b1; m_ill = 1'b1; end
        endcase
      end
    end
    if (valid) begin
      if (!m_halt && phase == 0) begin
        cur_op = m_mem[m_pc][15:12];
        cur_x  = m_mem[m_pc][11:0];
      end
      chk("m_halted", halted, m_halt);
      chk("m_illegal", illegal, m_ill);
      chk("m_we", mem_we, !m_halt && cur_op == 4'h2 && phase == 3 && !reset);
      chk("m_aluop", alu_opcode,
          (!m_halt && phase == 5 && cur_op >= 4'h3 && cur_op <= 4'h6) ? alu_code(cur_op) : 4'b0000);
      if (m_halt || phase == 0) begin
        chk("m_pc", pc, m_pc);
        chk("m_ac", ac, m_ac);
      end
      if (!m_halt && phase == 0) chk("m_fetch_addr", mem_addr, {4'b0000, m_pc});
      if (!m_halt && phase == 3 && cur_op >= 4'h1 && cur_op <= 4'h6) begin
        chk("m_oper_addr", mem_addr, {4'b0000, cur_x});
        if (cur_op == 4'h2) chk("m_wdata", mem_wdata, m_ac);
      end
    end
  end

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    mem[{4'b0000, a}] = d;
    m_mem[a] = d;
  endtask

  task automatic begin_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) m_mem[i] = 16'h0000;
  endtask

  task automatic end_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int n, wes, subs, sub_at;

  task automatic wait_halt();
    n = 0; wes = 0; subs = 0; sub_at = -1;
    while (!halted && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mem_we) wes++;
      if (alu_opcode == 4'b0001) begin subs++; sub_at = n; end
    end
    chk("halt_timeout", halted, 1'b1);
  endtask

  initial begin
    // Basic program
    begin_reset();
    poke(12'h000, 16'h1010); poke(12'h001, 16'h3011); poke(12'h002, 16'h2012);
    poke(12'h003, 16'h9000); poke(12'h010, 16'd5); poke(12'h011, 16'd7);
    end_reset();
    chk("t1_reset_pc", pc, 12'h000);
    chk("t1_reset_ac", ac, 16'h0000);
    chk("t1_reset_halted", halted, 1'b0);
    wait_halt();
    chk("t1_halt_cycle", n, 19);
    chk("t1_we_pulses", wes, 1);
    chk("t1_mem12", mem[16'h0012], 16'd12);
    chk("t1_ac", ac, 16'd12);
    chk("t1_pc", pc, 12'h004);

    // SUB wrap
    begin_reset();
    poke(12'h000, 16'h1010); poke(12'h001, 16'h4011); poke(12'h002, 16'h9000);
    poke(12'h010, 16'd3); poke(12'h011, 16'd5);
    end_reset();
    wait_halt();
    chk("t2_ac", ac, 16'hFFFE);
    chk("t2_sub_cycles", subs, 1);
    chk("t2_sub_at", sub_at, 11);
    chk("t2_halt_cycle", n, 15);

    // JZ taken
    begin_reset();
    poke(12'h000, 16'h8020); poke(12'h020, 16'h9000);
    end_reset();
    step(3);
    chk("t3_taken_addr", mem_addr, 16'h0020);
    chk("t3_taken_pc", pc, 12'h020);

    // JZ not taken
    begin_reset();
    poke(12'h000, 16'h1010); poke(12'h001, 16'h8020); poke(12'h002, 16'h9000);
    poke(12'h010, 16'd1); poke(12'h020, 16'h9000);
    end_reset();
    step(9);
    chk("t3_fall_addr", mem_addr, 16'h0002);
    chk("t3_fall_pc", pc, 12'h002);

    // Illegal opcode
    begin_reset();
    poke(12'h000, 16'hA123);
    end_reset();
    wes = 0;
    for (int i = 0; i < 3; i++) begin step(1); if (mem_we) wes++; end
    chk("t4_halted", halted, 1'b1);
    chk("t4_illegal", illegal, 1'b1);
    for (int i = 0; i < 20; i++) begin step(1); if (mem_we) wes++; end
    chk("t4_no_write", wes, 0);
    chk("t4_pc", pc, 12'h001);
    chk("t4_ac", ac, 16'h0000);

    // Reset during write
    begin_reset();
    poke(12'h000, 16'h1010); poke(12'h001, 16'h2012); poke(12'h010, 16'h55AA);
    poke(12'h012, 16'h1234);
    end_reset();
    step(9);
    chk("t5_in_write", mem_we, 1'b1);
    chk("t5_write_addr", mem_addr, 16'h0012);
    reset = 1'b1;
    #1;
    chk("t5_we_gated", mem_we, 1'b0);
    step(1);
    chk("t5_pc", pc, 12'h000);
    chk("t5_ac", ac, 16'h0000);
    chk("t5_fetch_addr", mem_addr, 16'h0000);
    chk("t5_mem12", mem[16'h0012], 16'h1234);

    // PC wrap
    begin_reset();
    poke(12'h000, 16'h7FFF); poke(12'hFFF, 16'h0000);
    end_reset();
    step(3);
    chk("t6_nop_addr", mem_addr, 16'h0FFF);
    step(3);
    chk("t6_pc", pc, 12'h000);
    chk("t6_wrap_addr", mem_addr, 16'h0000);

    // AND / OR / ADD carry-out chain
    begin_reset();
    poke(12'h000, 16'h1010); poke(12'h001, 16'h5011); poke(12'h002, 16'h6012);
    poke(12'h003, 16'h3013); poke(12'h004, 16'h2014); poke(12'h005, 16'h9000);
    poke(12'h010, 16'hF0F0); poke(12'h011, 16'h0FF0); poke(12'h012, 16'h1200);
    poke(12'h013, 16'hFFFF);
    end_reset();
    wait_halt();
    chk("t7_ac", ac, 16'h12EF);
    chk("t7_mem14", mem[16'h0014], 16'h12EF);
    chk("t7_halt_cycle", n, 31);
    chk("t7_we_pulses", wes, 1);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
